// File: rtl/avm_m1_pkg.sv
// Shared types and helpers for the Avalon-MM M1 round-robin arbiter.
package avm_m1_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int NREQ_MAX  = 4;
  localparam int GNT_MAX_W = 2;

  function automatic int gnt_width(input int nreq);
    return (nreq <= 2) ? 1 : $clog2(nreq);
  endfunction

  function automatic int cnt_width(input int max_pend);
    return $clog2(max_pend) + 1;
  endfunction

  // Widths for the default configuration (2 requesters, 4 outstanding reads).
  localparam int GNT_W      = gnt_width(2);
  localparam int PEND_CNT_W = cnt_width(4);

  // First eligible index after 'last', scanning upward modulo nreq.
  function automatic logic [GNT_MAX_W-1:0] rr_pick(
    input logic [NREQ_MAX-1:0]  eligible,
    input logic [GNT_MAX_W-1:0] last,
    input int                   nreq
  );
    logic [GNT_MAX_W-1:0] pick;
    logic                 found;
    int                   idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ_MAX; k++) begin
      idx = (int'(last) + k) % nreq;
      if (k <= nreq && !found && eligible[idx]) begin
        pick  = GNT_MAX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/avm_m1_rid_fifo.sv
// FIFO of requester IDs for outstanding reads; head names the owner of the next readdatavalid.
module avm_m1_rid_fifo
  import avm_m1_pkg::*;
#(
  parameter int W     = 1,
  parameter int DEPTH = 4
) (
  input  logic         q_clock,
  input  logic         q_reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    // DEPTH is a power of two, so the pointers wrap naturally.
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // NOTE: storage is not reset; cnt_q guards every read, so stale entries are never observed.
  always_ff @(posedge q_clock) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  // NOTE: sequential state always uses <= so every flop samples pre-edge values.
  always_ff @(posedge q_clock or posedge q_reset) begin
    if (q_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/avm_m1_arbiter.sv
// Round-robin arbiter sharing the avm_M1 master port among NREQ requesters,
// with pipelined reads routed back through a queue of requester IDs.
module avm_m1_arbiter
  import avm_m1_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int ADDR_W   = 30,
  parameter int DATA_W   = 32,
  parameter int MAX_PEND = 4
) (
  input  logic                       q_clock,
  input  logic                       q_reset,
  input  logic [NREQ*ADDR_W-1:0]     r_address,
  input  logic [NREQ*DATA_W-1:0]     r_writedata,
  input  logic [NREQ*DATA_W/8-1:0]   r_byteenable,
  input  logic [NREQ-1:0]            r_read,
  input  logic [NREQ-1:0]            r_write,
  output logic [NREQ-1:0]            r_waitrequest,
  output logic [DATA_W-1:0]          r_readdata,
  output logic [NREQ-1:0]            r_readdatavalid,
  output logic [ADDR_W-1:0]          avm_address,
  output logic [DATA_W-1:0]          avm_writedata,
  output logic [DATA_W/8-1:0]        avm_byteenable,
  output logic                       avm_read,
  output logic                       avm_write,
  output logic                       avm_begintransfer,
  input  logic                       avm_waitrequest,
  input  logic [DATA_W-1:0]          avm_readdata,
  input  logic                       avm_readdatavalid,
  output logic                       pend_full,
  output logic                       err_orphan
);

  localparam int BE_W = DATA_W / 8;
  localparam int GW   = gnt_width(NREQ);

  state_e             state_q, state_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [GW-1:0]      last_q, last_d;
  logic               first_q, first_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_orphan_q, err_orphan_d;

  logic [NREQ-1:0]    eligible;
  logic [GW-1:0]      pick;
  logic               sel_read, sel_write;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [GW-1:0]      fifo_dout;

  avm_m1_rid_fifo #(
    .W     (GW),
    .DEPTH (MAX_PEND)
  ) u_rid_fifo (
    .q_clock (q_clock),
    .q_reset (q_reset),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (grant_q),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // A read-only request must wait while the ID queue is full; a write never does.
  assign eligible  = r_write | (r_read & {NREQ{~fifo_full}});
  assign pick      = GW'(rr_pick(NREQ_MAX'(eligible), GNT_MAX_W'(last_q), NREQ));
  assign sel_read  = r_read[grant_q];
  assign sel_write = r_write[grant_q];
  assign pend_full  = fifo_full;
  assign err_orphan = err_orphan_q;

  // NOTE: every output and next-state value gets a default first, so no path infers a latch.
  always_comb begin
    state_d           = state_q;
    grant_d           = grant_q;
    last_d            = last_q;
    first_d           = 1'b0;
    fifo_push         = 1'b0;
    avm_address       = '0;
    avm_writedata     = '0;
    avm_byteenable    = '0;
    avm_read          = 1'b0;
    avm_write         = 1'b0;
    avm_begintransfer = 1'b0;
    r_waitrequest     = '1;

    case (state_q)
      IDLE: begin
        if (|eligible) begin
          grant_d = pick;
          first_d = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        avm_address       = r_address[int'(grant_q)*ADDR_W +: ADDR_W];
        avm_writedata     = r_writedata[int'(grant_q)*DATA_W +: DATA_W];
        avm_byteenable    = r_byteenable[int'(grant_q)*BE_W +: BE_W];
        avm_write         = sel_write;
        avm_read          = sel_read & ~sel_write;
        avm_begintransfer = first_q & (sel_read | sel_write);
        r_waitrequest[grant_q] = avm_waitrequest;
        if (!sel_read && !sel_write) begin
          // Requester abandoned its command: release the port without crediting it.
          state_d = IDLE;
        end else if (!avm_waitrequest) begin
          fifo_push = sel_read & ~sel_write;
          last_d    = grant_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    r_readdatavalid = '0;
    fifo_pop        = avm_readdatavalid & ~fifo_empty;
    if (fifo_pop) r_readdatavalid[fifo_dout] = 1'b1;
    r_readdata   = avm_readdatavalid ? avm_readdata : rdata_q;
    rdata_d      = r_readdata;
    err_orphan_d = err_orphan_q | (avm_readdatavalid & fifo_empty);
  end

  always_ff @(posedge q_clock or posedge q_reset) begin
    if (q_reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_q       <= GW'(NREQ - 1);
      first_q      <= 1'b0;
      rdata_q      <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      first_q      <= first_d;
      rdata_q      <= rdata_d;
      err_orphan_q <= err_orphan_d;
    end
  end

endmodule
